// File: rtl/if_stage_pkg.sv
// Shared MIPS fetch-stage definitions: datapath defaults, opcodes shared with the decoder,
// and the next-PC source encoding.
package if_stage_pkg;

  localparam int unsigned      DEF_DATA_W    = 32;
  localparam logic [31:0]      DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]      DEF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef enum logic [1:0] {
    NpcSeq,
    NpcHold,
    NpcBranch,
    NpcJump
  } npc_sel_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls from ID, ROM read path, and the IF/ID outputs.
interface if_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              stall;
  logic              flush;
  logic              branch_taken;
  logic [15:0]       branch_imm;
  logic              jump;
  logic [25:0]       jump_index;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] i_out;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] if_id_instr;
  logic [DATA_W-1:0] if_id_pc4;
  logic              if_id_valid;

  modport master (
    output stall, flush, branch_taken, branch_imm, jump, jump_index, i_out,
    input  address, pc, if_id_instr, if_id_pc4, if_id_valid
  );

  modport slave (
    input  stall, flush, branch_taken, branch_imm, jump, jump_index, i_out,
    output address, pc, if_id_instr, if_id_pc4, if_id_valid
  );
endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter register with synchronous reset to RESET_PC and a load enable.
module if_stage_pc_reg #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_en) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, next-PC selection (jump > branch > stall > PC+4)
// and the IF/ID pipeline register with bubble insertion on flush or redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [DATA_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.slave   bus
);

  logic [DATA_W-1:0] w_pc;
  logic [DATA_W-1:0] w_pc4;
  logic [DATA_W-1:0] w_br_tgt;
  logic [DATA_W-1:0] w_j_tgt;
  logic [DATA_W-1:0] w_next_pc;
  logic              w_jump;
  logic              w_branch;
  logic              w_redirect;
  logic              w_pc_en;
  npc_sel_e          w_npc_sel;

  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_pc4;
  logic              r_valid;

  // Redirects from a bubble in ID are stale and must be ignored.
  assign w_jump     = bus.jump & r_valid;
  assign w_branch   = bus.branch_taken & r_valid;
  assign w_redirect = w_jump | w_branch;
  assign w_pc_en    = ~bus.stall | w_redirect;

  assign w_pc4    = w_pc + DATA_W'(4);
  assign w_br_tgt = r_pc4 + {{(DATA_W-18){bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
  assign w_j_tgt  = {r_pc4[DATA_W-1:28], bus.jump_index, 2'b00};

  always_comb begin
    w_npc_sel = NpcSeq;
    if (w_jump) begin
      w_npc_sel = NpcJump;
    end else if (w_branch) begin
      w_npc_sel = NpcBranch;
    end else if (bus.stall) begin
      w_npc_sel = NpcHold;
    end
  end

  always_comb begin
    w_next_pc = w_pc4;
    unique case (w_npc_sel)
      NpcJump:   w_next_pc = w_j_tgt;
      NpcBranch: w_next_pc = w_br_tgt;
      NpcHold:   w_next_pc = w_pc;
      default:   w_next_pc = w_pc4;
    endcase
  end

  if_stage_pc_reg #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_pc_en),
    .i_d  (w_next_pc),
    .o_q  (w_pc)
  );

  // No delay slot: the wrong-path fetch is squashed on any redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (bus.flush | w_redirect) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_instr <= bus.i_out;
      r_pc4   <= w_pc4;
      r_valid <= 1'b1;
    end
  end

  assign bus.address     = {2'b00, w_pc[DATA_W-1:2]};
  assign bus.pc          = w_pc;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_pc4   = r_pc4;
  assign bus.if_id_valid = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a 32-word ROM feeds two instances, one with the default
// reset PC and one reset to the top word to exercise PC wrap-around.
module tb_if_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] rom [32];

  if_stage_if #(.DATA_W(32)) bus ();
  if_stage_if #(.DATA_W(32)) bus2 ();

  if_stage #(
    .DATA_W    (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_stage #(
    .DATA_W    (32),
    .RESET_PC  (32'hFFFF_FFFC),
    .NOP_INSTR (32'h0000_0000)
  ) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus.i_out  = rom[bus.address[4:0]];
  assign bus2.i_out = rom[bus2.address[4:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0; bus.branch_imm = 16'h0;
    bus.jump = 1'b0; bus.jump_index = 26'h0;
    bus2.stall = 1'b0; bus2.flush = 1'b0; bus2.branch_taken = 1'b0; bus2.branch_imm = 16'h0;
    bus2.jump = 1'b0; bus2.jump_index = 26'h0;
  endtask

  // Reset, release, and fetch 4 words so ID holds pc4=16 with pc=16.
  task automatic restart_to_16;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (bus.pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h0); end
    checks++; if (bus.address !== 32'h0) begin
      errors++; $display("FAIL reset_addr got %h want %h", bus.address, 32'h0); end
    checks++; if (bus.if_id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus.if_id_valid); end
    checks++; if (bus.if_id_instr !== 32'h0) begin
      errors++; $display("FAIL reset_instr got %h want %h", bus.if_id_instr, 32'h0); end
    checks++; if (bus.if_id_pc4 !== 32'h0) begin
      errors++; $display("FAIL reset_pc4 got %h want %h", bus.if_id_pc4, 32'h0); end
  endtask

  task automatic test_fetch;
    rst = 1'b0;
    tick();
    checks++; if (bus.pc !== 32'h4) begin
      errors++; $display("FAIL fetch0_pc got %h want %h", bus.pc, 32'h4); end
    checks++; if (bus.if_id_instr !== rom[0]) begin
      errors++; $display("FAIL fetch0_instr got %h want %h", bus.if_id_instr, rom[0]); end
    checks++; if (bus.if_id_pc4 !== 32'h4) begin
      errors++; $display("FAIL fetch0_pc4 got %h want %h", bus.if_id_pc4, 32'h4); end
    checks++; if (bus.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL fetch0_valid got %b want 1", bus.if_id_valid); end
    tick();
    checks++; if (bus.pc !== 32'h8) begin
      errors++; $display("FAIL fetch1_pc got %h want %h", bus.pc, 32'h8); end
    checks++; if (bus.address !== 32'h2) begin
      errors++; $display("FAIL fetch1_addr got %h want %h", bus.address, 32'h2); end
    checks++; if (bus.if_id_instr !== rom[1]) begin
      errors++; $display("FAIL fetch1_instr got %h want %h", bus.if_id_instr, rom[1]); end
    checks++; if (bus.if_id_pc4 !== 32'h8) begin
      errors++; $display("FAIL fetch1_pc4 got %h want %h", bus.if_id_pc4, 32'h8); end
  endtask

  task automatic test_stall;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pc !== 32'h8) begin
        errors++; $display("FAIL stall_pc[%0d] got %h want %h", i, bus.pc, 32'h8); end
      checks++; if (bus.if_id_instr !== rom[1] || bus.if_id_pc4 !== 32'h8) begin
        errors++; $display("FAIL stall_ifid[%0d] got %h/%h want %h/%h", i, bus.if_id_instr,
                           bus.if_id_pc4, rom[1], 32'h8); end
    end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.pc !== 32'hC) begin
      errors++; $display("FAIL unstall_pc got %h want %h", bus.pc, 32'hC); end
    checks++; if (bus.if_id_instr !== rom[2]) begin
      errors++; $display("FAIL unstall_instr got %h want %h", bus.if_id_instr, rom[2]); end
  endtask

  task automatic test_branch;
    tick();
    checks++; if (bus.if_id_pc4 !== 32'h10) begin
      errors++; $display("FAIL br_setup_pc4 got %h want %h", bus.if_id_pc4, 32'h10); end
    bus.branch_taken = 1'b1;
    bus.branch_imm   = 16'hFFFC;
    tick();
    bus.branch_taken = 1'b0;
    bus.branch_imm   = 16'h0;
    checks++; if (bus.pc !== 32'h0) begin
      errors++; $display("FAIL br_pc got %h want %h", bus.pc, 32'h0); end
    checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) begin
      errors++; $display("FAIL br_bubble got %b/%h want 0/%h", bus.if_id_valid,
                         bus.if_id_instr, 32'h0); end
    tick();
    checks++; if (bus.if_id_instr !== rom[0] || bus.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL br_refetch got %h/%b want %h/1", bus.if_id_instr,
                         bus.if_id_valid, rom[0]); end
  endtask

  task automatic test_jump;
    restart_to_16();
    bus.jump       = 1'b1;
    bus.jump_index = 26'h000001F;
    tick();
    bus.jump = 1'b0;
    checks++; if (bus.pc !== 32'h7C) begin
      errors++; $display("FAIL jmp_pc got %h want %h", bus.pc, 32'h7C); end
    checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_pc4 !== 32'h0) begin
      errors++; $display("FAIL jmp_bubble got %b/%h want 0/%h", bus.if_id_valid,
                         bus.if_id_pc4, 32'h0); end
    restart_to_16();
    bus.jump         = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_imm   = 16'hFFFC;
    tick();
    bus.jump         = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_imm   = 16'h0;
    checks++; if (bus.pc !== 32'h7C) begin
      errors++; $display("FAIL jmp_vs_br_pc got %h want %h", bus.pc, 32'h7C); end
    tick();
    checks++; if (bus.if_id_instr !== rom[31] || bus.if_id_pc4 !== 32'h80) begin
      errors++; $display("FAIL jmp_target_fetch got %h/%h want %h/%h", bus.if_id_instr,
                         bus.if_id_pc4, rom[31], 32'h80); end
  endtask

  task automatic test_flush_stall;
    restart_to_16();
    tick();
    checks++; if (bus.pc !== 32'h14 || bus.if_id_instr !== rom[4]) begin
      errors++; $display("FAIL fs_setup got %h/%h want %h/%h", bus.pc, bus.if_id_instr,
                         32'h14, rom[4]); end
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    checks++; if (bus.pc !== 32'h14) begin
      errors++; $display("FAIL fs_pc got %h want %h", bus.pc, 32'h14); end
    checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) begin
      errors++; $display("FAIL fs_bubble got %b/%h want 0/%h", bus.if_id_valid,
                         bus.if_id_instr, 32'h0); end
    // Branch while ID holds a bubble must be ignored.
    bus.branch_taken = 1'b1;
    bus.branch_imm   = 16'hFFFC;
    tick();
    bus.branch_taken = 1'b0;
    bus.branch_imm   = 16'h0;
    checks++; if (bus.pc !== 32'h18) begin
      errors++; $display("FAIL br_unqual_pc got %h want %h", bus.pc, 32'h18); end
    checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_instr !== rom[5]) begin
      errors++; $display("FAIL br_unqual_ifid got %b/%h want 1/%h", bus.if_id_valid,
                         bus.if_id_instr, rom[5]); end
  endtask

  task automatic test_wrap_and_reset;
    rst = 1'b1;
    tick();
    checks++; if (bus2.pc !== 32'hFFFF_FFFC || bus2.address !== 32'h3FFF_FFFF) begin
      errors++; $display("FAIL wrap_reset got %h/%h want %h/%h", bus2.pc, bus2.address,
                         32'hFFFF_FFFC, 32'h3FFF_FFFF); end
    rst = 1'b0;
    tick();
    checks++; if (bus2.pc !== 32'h0) begin
      errors++; $display("FAIL wrap_pc got %h want %h", bus2.pc, 32'h0); end
    checks++; if (bus2.if_id_pc4 !== 32'h0 || bus2.if_id_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_pc4 got %h/%b want %h/1", bus2.if_id_pc4,
                         bus2.if_id_valid, 32'h0); end
    checks++; if (bus2.if_id_instr !== rom[31]) begin
      errors++; $display("FAIL wrap_instr got %h want %h", bus2.if_id_instr, rom[31]); end
    bus.stall = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h4) begin
      errors++; $display("FAIL pre_rst_stall_pc got %h want %h", bus.pc, 32'h4); end
    bus.jump       = 1'b1;
    bus.jump_index = 26'h000001F;
    rst            = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h0 || bus.if_id_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stall got %h/%b want %h/0", bus.pc,
                         bus.if_id_valid, 32'h0); end
    checks++; if (bus.if_id_instr !== 32'h0 || bus.if_id_pc4 !== 32'h0) begin
      errors++; $display("FAIL rst_mid_stall_ifid got %h/%h want %h/%h", bus.if_id_instr,
                         bus.if_id_pc4, 32'h0, 32'h0); end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) begin
      rom[i] = 32'h2008_0000 + 32'(i * 3 + 1);
    end
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_jump();
    test_flush_stall();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
